// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: PC request side, instruction memory side
// and decoder side of the instruction fetch unit.
interface instr_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] PCAddr;
    logic              GetInstruction;
    logic              Flush;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemRd;
    logic [DATA_W-1:0] MemData;
    logic              MemReady;
    logic [DATA_W-1:0] Instr;
    logic [ADDR_W-1:0] InstrAddr;
    logic              InstrValid;
    logic              InstrAccept;
    logic              FetchError;

    modport master (
        input  PCAddr, GetInstruction, Flush,
        input  MemData, MemReady, InstrAccept,
        output MemAddr, MemRd,
        output Instr, InstrAddr, InstrValid, FetchError
    );

    modport slave (
        output PCAddr, GetInstruction, Flush,
        output MemData, MemReady, InstrAccept,
        input  MemAddr, MemRd,
        input  Instr, InstrAddr, InstrValid, FetchError
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding memory read, one-entry
// pending request buffer, decoder handshake, flush and read timeout.
module instr_fetch #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        ERR
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] fetch_addr, fetch_addr_n;
    logic              mem_rd, mem_rd_n;
    logic [DATA_W-1:0] instr, instr_n;
    logic [ADDR_W-1:0] instr_addr, instr_addr_n;
    logic              instr_vld, instr_vld_n;
    logic              fetch_err, fetch_err_n;
    logic              pend_vld, pend_vld_n;
    logic [ADDR_W-1:0] pend_addr, pend_addr_n;
    logic [7:0]        cnt, cnt_n;

    // Register the whole stage; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_addr <= '0;
            mem_rd     <= 1'b0;
            instr      <= '0;
            instr_addr <= '0;
            instr_vld  <= 1'b0;
            fetch_err  <= 1'b0;
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            fetch_addr <= fetch_addr_n;
            mem_rd     <= mem_rd_n;
            instr      <= instr_n;
            instr_addr <= instr_addr_n;
            instr_vld  <= instr_vld_n;
            fetch_err  <= fetch_err_n;
            pend_vld   <= pend_vld_n;
            pend_addr  <= pend_addr_n;
            cnt        <= cnt_n;
        end
    end

    // Next-state and next-output decode; Flush beats the handshake.
    always_comb begin
        state_n      = state;
        fetch_addr_n = fetch_addr;
        mem_rd_n     = mem_rd;
        instr_n      = instr;
        instr_addr_n = instr_addr;
        instr_vld_n  = instr_vld;
        fetch_err_n  = fetch_err;
        pend_vld_n   = pend_vld;
        pend_addr_n  = pend_addr;
        cnt_n        = cnt;

        if (bus.Flush) begin
            state_n     = IDLE;
            mem_rd_n    = 1'b0;
            instr_vld_n = 1'b0;
            fetch_err_n = 1'b0;
            pend_vld_n  = 1'b0;
            cnt_n       = '0;
            if (bus.GetInstruction) begin
                fetch_addr_n = bus.PCAddr;
                mem_rd_n     = 1'b1;
                state_n      = REQ;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.GetInstruction) begin
                        fetch_addr_n = bus.PCAddr;
                        mem_rd_n     = 1'b1;
                        state_n      = REQ;
                    end
                end
                REQ: begin
                    if (bus.GetInstruction) begin
                        pend_vld_n  = 1'b1;
                        pend_addr_n = bus.PCAddr;
                    end
                    if (bus.MemReady) begin
                        instr_n      = bus.MemData;
                        instr_addr_n = fetch_addr;
                        instr_vld_n  = 1'b1;
                        mem_rd_n     = 1'b0;
                        cnt_n        = '0;
                        state_n      = HOLD;
                    end else if (cnt == CNT_MAX) begin
                        mem_rd_n    = 1'b0;
                        fetch_err_n = 1'b1;
                        state_n     = ERR;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (bus.InstrAccept) begin
                        instr_vld_n = 1'b0;
                        if (bus.GetInstruction) begin
                            fetch_addr_n = bus.PCAddr;
                            mem_rd_n     = 1'b1;
                            pend_vld_n   = 1'b0;
                            state_n      = REQ;
                        end else if (pend_vld) begin
                            fetch_addr_n = pend_addr;
                            mem_rd_n     = 1'b1;
                            pend_vld_n   = 1'b0;
                            state_n      = REQ;
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (bus.GetInstruction) begin
                        pend_vld_n  = 1'b1;
                        pend_addr_n = bus.PCAddr;
                    end
                end
                ERR: begin
                    state_n = ERR;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign bus.MemAddr    = fetch_addr;
    assign bus.MemRd      = mem_rd;
    assign bus.Instr      = instr;
    assign bus.InstrAddr  = instr_addr;
    assign bus.InstrValid = instr_vld;
    assign bus.FetchError = fetch_err;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction model.
module tb_instr_fetch;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    instr_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instr_fetch #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a read in flight, an instruction held for the
    // decoder, a sticky error, and at most one queued PC (newest wins).
    bit          m_busy, m_have, m_err;
    int          m_age;
    logic [31:0] m_addr, m_instr, m_iaddr;
    logic [31:0] pend_q[$];

    task automatic m_start(logic [31:0] a);
        m_addr = a;
        m_busy = 1'b1;
        m_age  = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_have = 0; m_err = 0; m_age = 0;
            m_addr = 0; m_instr = 0; m_iaddr = 0;
            pend_q.delete();
        end else if (bus.Flush) begin
            m_busy = 0; m_have = 0; m_err = 0; m_age = 0;
            pend_q.delete();
            if (bus.GetInstruction) m_start(bus.PCAddr);
        end else if (m_err) begin
            m_err = 1'b1;
        end else if (m_busy) begin
            if (bus.GetInstruction) begin
                pend_q.delete();
                pend_q.push_back(bus.PCAddr);
            end
            m_age++;
            if (bus.MemReady) begin
                m_instr = bus.MemData;
                m_iaddr = m_addr;
                m_have  = 1;
                m_busy  = 0;
            end else if (m_age == TO) begin
                m_busy = 0;
                m_err  = 1;
            end
        end else if (m_have) begin
            if (bus.InstrAccept) begin
                m_have = 0;
                if (bus.GetInstruction) begin
                    pend_q.delete();
                    m_start(bus.PCAddr);
                end else if (pend_q.size() > 0) begin
                    m_start(pend_q.pop_front());
                end
            end else if (bus.GetInstruction) begin
                pend_q.delete();
                pend_q.push_back(bus.PCAddr);
            end
        end else if (bus.GetInstruction) begin
            m_start(bus.PCAddr);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m.MemRd", 32'(bus.MemRd), 32'(m_busy));
            chk("m.InstrValid", 32'(bus.InstrValid), 32'(m_have));
            chk("m.FetchError", 32'(bus.FetchError), 32'(m_err));
            chk("m.MemAddr", bus.MemAddr, m_addr);
            if (m_have) begin
                chk("m.Instr", bus.Instr, m_instr);
                chk("m.InstrAddr", bus.InstrAddr, m_iaddr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.GetInstruction = 0;
        bus.Flush          = 0;
        bus.MemReady       = 0;
        bus.InstrAccept    = 0;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, ".MemAddr"}, bus.MemAddr, 0);
        chk({tag, ".MemRd"}, 32'(bus.MemRd), 0);
        chk({tag, ".Instr"}, bus.Instr, 0);
        chk({tag, ".InstrAddr"}, bus.InstrAddr, 0);
        chk({tag, ".InstrValid"}, 32'(bus.InstrValid), 0);
        chk({tag, ".FetchError"}, 32'(bus.FetchError), 0);
    endtask

    initial begin
        rst = 1;
        idle();
        bus.PCAddr  = 0;
        bus.MemData = 0;
        tick();
        chk_en = 1;
        tick();
        chk_all_zero("reset");
        rst = 0;

        // Zero-wait fetch of address 0
        bus.GetInstruction = 1; bus.PCAddr = 32'h0;
        tick();
        idle();
        bus.MemReady = 1; bus.MemData = 32'hDEADBEEF;
        chk("t1.MemRd", 32'(bus.MemRd), 1);
        chk("t1.MemAddr", bus.MemAddr, 0);
        chk("t1.InstrValid0", 32'(bus.InstrValid), 0);
        tick();
        idle();
        chk("t1.MemRdDrop", 32'(bus.MemRd), 0);
        chk("t1.InstrValid", 32'(bus.InstrValid), 1);
        chk("t1.Instr", bus.Instr, 32'hDEADBEEF);
        chk("t1.InstrAddr", bus.InstrAddr, 0);

        // Stall the decoder while two strobes arrive; newest wins
        for (int i = 0; i < 5; i++) begin
            bus.GetInstruction = (i < 2);
            bus.PCAddr = (i == 0) ? 32'h10 : 32'h11;
            tick();
            idle();
            chk("t2.Instr", bus.Instr, 32'hDEADBEEF);
            chk("t2.Valid", 32'(bus.InstrValid), 1);
        end
        bus.InstrAccept = 1;
        tick();
        idle();
        chk("t2.MemRd", 32'(bus.MemRd), 1);
        chk("t2.MemAddr", bus.MemAddr, 32'h11);
        chk("t2.Valid0", 32'(bus.InstrValid), 0);
        bus.MemReady = 1; bus.MemData = 32'hAAAA0011;
        tick();
        idle();
        chk("t2.Instr2", bus.Instr, 32'hAAAA0011);
        chk("t2.InstrAddr", bus.InstrAddr, 32'h11);

        // Accept together with a strobe redirects immediately
        bus.InstrAccept = 1; bus.GetInstruction = 1; bus.PCAddr = 32'h20;
        tick();
        idle();
        chk("t3.MemRd", 32'(bus.MemRd), 1);
        chk("t3.MemAddr", bus.MemAddr, 32'h20);
        chk("t3.Valid", 32'(bus.InstrValid), 0);

        // Timeout: 16 REQ cycles then error
        for (int i = 1; i < TO; i++) tick();
        chk("t4.MemRdLast", 32'(bus.MemRd), 1);
        chk("t4.ErrLast", 32'(bus.FetchError), 0);
        tick();
        chk("t4.MemRd", 32'(bus.MemRd), 0);
        chk("t4.Err", 32'(bus.FetchError), 1);
        bus.GetInstruction = 1; bus.PCAddr = 32'h50;
        tick();
        idle();
        chk("t4.IgnRd", 32'(bus.MemRd), 0);
        chk("t4.IgnErr", 32'(bus.FetchError), 1);
        bus.Flush = 1;
        tick();
        idle();
        chk("t4.FlushErr", 32'(bus.FetchError), 0);
        chk("t4.FlushRd", 32'(bus.MemRd), 0);

        // Flush-and-redirect with a stale response on the flush cycle
        bus.GetInstruction = 1; bus.PCAddr = 32'h30;
        tick();
        idle();
        bus.Flush = 1; bus.GetInstruction = 1; bus.PCAddr = 32'h40;
        bus.MemReady = 1; bus.MemData = 32'h1234;
        tick();
        idle();
        chk("t5.MemAddr", bus.MemAddr, 32'h40);
        chk("t5.MemRd", 32'(bus.MemRd), 1);
        chk("t5.Valid", 32'(bus.InstrValid), 0);
        bus.MemReady = 1; bus.MemData = 32'h5678;
        tick();
        idle();
        chk("t5.Instr", bus.Instr, 32'h5678);
        chk("t5.InstrAddr", bus.InstrAddr, 32'h40);

        // Reset in HOLD with a pending request
        bus.GetInstruction = 1; bus.PCAddr = 32'h60;
        tick();
        idle();
        rst = 1;
        tick();
        rst = 0;
        chk_all_zero("t6");
        bus.GetInstruction = 1; bus.PCAddr = 32'h70;
        tick();
        idle();
        chk("t6.MemRd", 32'(bus.MemRd), 1);
        chk("t6.MemAddr", bus.MemAddr, 32'h70);
        bus.MemReady = 1; bus.MemData = 32'hCAFE;
        tick();
        idle();
        chk("t6.Instr", bus.Instr, 32'hCAFE);
        bus.InstrAccept = 1;
        tick();
        idle();
        chk("t6.NoPend", 32'(bus.MemRd), 0);
        chk("t6.Idle", 32'(bus.InstrValid), 0);

        // Random traffic, alternating fast and slow memory windows
        for (int i = 0; i < 4000; i++) begin
            rst                = ($urandom_range(0, 199) == 0);
            bus.Flush          = ($urandom_range(0, 39) == 0);
            bus.GetInstruction = ($urandom_range(0, 2) == 0);
            bus.PCAddr         = $urandom;
            bus.MemData        = $urandom;
            bus.InstrAccept    = $urandom_range(0, 1) != 0;
            if ((i / 500) % 2 == 1)
                bus.MemReady = ($urandom_range(0, 11) == 0);
            else
                bus.MemReady = ($urandom_range(0, 1) == 0);
            tick();
        end
        rst = 0;
        idle();
        tick();
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
